framebuffer_writer: RTL
=======================

// Module: framebuffer_writer
// PURPOSE
//   Write side of the pixel framebuffer that the VGA path scans out.
//   Accepts pixel-write and screen-fill requests from the ASIP core over a valid/ready handshake.
//   Converts (x,y) to a linear address y*screenX+x and drives one memory write port.
//   Also counts requests that were dropped because their coordinates were off-screen.
// PARAMETERS
//   ColorBits  3       bits per stored pixel (matches framebuffer word)
//   screenX    320     visible columns
//   screenY    240     visible rows
//   AddrBits   17      framebuffer address width; must satisfy 2**AddrBits >= screenX*screenY
// PORTS
//   clock          in   1          system clock; all logic on rising edge
//   reset          in   1          asynchronous, active-low reset
//   req_valid      in   1          request present
//   req_ready      out  1          block can accept a request this cycle
//   req_x          in   9          pixel column
//   req_y          in   8          pixel row
//   req_color      in   ColorBits  pixel value
//   req_fill       in   1          1 = fill whole screen with req_color; x/y ignored
//   busy           out  1          fill in progress
//   dropped_count  out  8          saturating count of off-screen single writes
//   mem_we         out  1          framebuffer write enable
//   mem_addr       out  AddrBits   framebuffer write address
//   mem_data       out  ColorBits  framebuffer write data
// BEHAVIOUR
//   Reset (async, reset==0) values:
//     - state=IDLE.
//     - req_ready=0, busy=0, mem_we=0, mem_addr=0, mem_data=0, dropped_count=0.
//     - req_ready is 1 from the first clock edge after reset deasserts.
//   Handshake: a request is accepted on a rising edge with req_valid && req_ready. Inputs are sampled only then.
//   States:
//     - IDLE: req_ready=1.
//       - Accept with req_fill=0, x<screenX and y<screenY: next cycle mem_we=1,
//         mem_addr=y*screenX+x, mem_data=req_color. Stay in IDLE.
//         Latency is 1 cycle; throughput is 1 write/cycle (back-to-back accepts allowed).
//       - Accept with req_fill=0 and x>=screenX or y>=screenY: no write. dropped_count+=1, saturating at 255.
//       - Accept with req_fill=1: latch color, go to FILL. req_ready=0 and busy=1 from the next cycle.
//     - FILL: each cycle mem_we=1, mem_data=latched color, mem_addr counts 0,1,...,screenX*screenY-1.
//       The first fill write is in the cycle after accept.
//       - After the write to the last address, return to IDLE. Next cycle: busy=0, req_ready=1, mem_we=0.
//       - A fill takes exactly screenX*screenY write cycles.
//       - The fill address comes from an incrementing counter (no multiplier). The single-write path may use a
//         multiply or shift-add (320 = 256+64).
//   mem_we is 0 in every cycle without a write; mem_addr and mem_data hold their last values.
//   Arithmetic:
//     - The y*screenX+x computation is performed at AddrBits width with no truncation for in-range coordinates.
//     - Range checks use unsigned compares.
//   Reset mid-fill aborts immediately. The remaining addresses are not written and all outputs take their reset values.
//   req_valid is ignored while in FILL (no queuing). The requester holds its request until req_ready.
// TESTING
//   1. After reset release, valid x=0,y=0,color=5 -> next cycle mem_we=1, addr=0, data=5.
//   2. Back-to-back accepts (319,239,c=7) then (10,1,c=2) -> writes addr=76799 d=7, then addr=330 d=2, consecutive cycles.
//   3. Requests x=320,y=0 and x=0,y=240 -> no mem_we, dropped_count 0->1->2; 260 more drops -> saturates at 255.
//   4. Fill color=3 -> busy=1, req_ready=0 for 76800 cycles; writes addr 0..76799 data=3; then busy=0, req_ready=1.
//   5. Assert reset at fill cycle 1000 -> mem_we=0, busy=0, addr=0 immediately.
//      After release, a single write (5,5,c=1) -> addr=1605.
//   6. req_valid held high with a pixel during a fill -> not accepted until the fill ends, then written once.

Source files
------------

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - write port of the VGA pixel framebuffer
//
// Purpose: accepts single-pixel writes and whole-screen fills over a
// valid/ready handshake and drives one framebuffer write port. Off-screen
// single writes are dropped and counted.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_x, req_y        pixel coordinates (ignored for fills)
//   req_color           pixel value
//   req_fill            1 = fill the whole screen with req_color
//   busy                fill in progress
//   dropped_count       saturating count of off-screen single writes
//   mem_we/addr/data    framebuffer write port
module framebuffer_writer #(
  parameter int unsigned ColorBits = 3,
  parameter int unsigned screenX   = 320,
  parameter int unsigned screenY   = 240,
  parameter int unsigned AddrBits  = 17
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [8:0]           req_x,
  input  logic [7:0]           req_y,
  input  logic [ColorBits-1:0] req_color,
  input  logic                 req_fill,
  output logic                 busy,
  output logic [7:0]           dropped_count,
  output logic                 mem_we,
  output logic [AddrBits-1:0]  mem_addr,
  output logic [ColorBits-1:0] mem_data
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(screenX * screenY - 1);
  localparam logic [AddrBits-1:0] RowPitch = AddrBits'(screenX);

  state_t                 state, state_n;
  logic                   ready_n, busy_n, we_n;
  logic [AddrBits-1:0]    addr_n;
  logic [ColorBits-1:0]   data_n;
  logic [7:0]             drop_n;
  logic                   accept, on_screen;
  logic [AddrBits-1:0]    pix_addr;

  assign accept    = req_valid && req_ready;
  assign on_screen = (32'(req_x) < screenX) && (32'(req_y) < screenY);
  assign pix_addr  = AddrBits'(req_y) * RowPitch + AddrBits'(req_x);

  // During a fill mem_addr itself is the fill counter; the fill ends once the
  // last address has been presented for one cycle.
  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    data_n  = mem_data;
    drop_n  = dropped_count;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fill) begin
            state_n = FILL;
            we_n    = 1'b1;
            addr_n  = '0;
            data_n  = req_color;
          end else if (on_screen) begin
            we_n   = 1'b1;
            addr_n = pix_addr;
            data_n = req_color;
          end else if (dropped_count != 8'hFF) begin
            drop_n = dropped_count + 8'd1;
          end
        end
      end
      FILL: begin
        if (mem_addr == LastAddr) begin
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = mem_addr + AddrBits'(1);
        end
      end
    endcase
    // Registered handshake outputs track the state being entered so that
    // ready drops the cycle after a fill is accepted and rises right after it.
    ready_n = (state_n == IDLE);
    busy_n  = (state_n == FILL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      busy          <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      dropped_count <= '0;
    end else begin
      state         <= state_n;
      req_ready     <= ready_n;
      busy          <= busy_n;
      mem_we        <= we_n;
      mem_addr      <= addr_n;
      mem_data      <= data_n;
      dropped_count <= drop_n;
    end
  end

endmodule
